sample_window_feeder: RTL and testbench
=======================================

# sample_window_feeder

Upstream feeder for the 1024-sample histogram/mode counter. It accepts 8-bit samples over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Samples drain one per cycle as the `write`/`data` strobe pair the histogram stage consumes. It tracks position within the current window and pulses `window_done` on the last sample of each window, so the downstream stage and software know when a full histogram window has been delivered.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `WINDOW`, default 1024: samples per histogram window; ≥ 2.
- One clock, `clk`. Reset `rst` is synchronous and active-high.
- `clk` input 1: rising-edge clock for all state.
- `rst` input 1: synchronous reset, active-high.
- `flush` input 1: synchronous clear of FIFO contents and window position.
- `in_valid` input 1: upstream sample present.
- `in_data` input 8: sample value.
- `in_ready` output 1: FIFO can accept; a sample transfers on a rising edge where `in_valid & in_ready`.
- `hold` input 1: downstream stall; no sample is drained while high.
- `write` output 1: registered strobe, one sample delivered this cycle.
- `data` output 8: registered sample, valid while `write` = 1.
- `fill` output $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `window_cnt` output $clog2(WINDOW): samples already delivered in the current window.
- `window_done` output 1: registered pulse, coincident with the `write` of the WINDOW-th sample.

## Operation
- Storage: circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus the `fill` counter. Full is `fill == DEPTH`; empty is `fill == 0`.
- `in_ready = ~rst & ~flush & (fill != DEPTH)`.
  - A full FIFO never accepts input, even in a cycle where it also drains (no pass-through).
- Push occurs when `in_valid & in_ready`. The sample is written at the write pointer and the write pointer increments.
- Pop occurs when `fill != 0 & ~hold & ~flush`.
  - On the following edge: `write` = 1, `data` = head entry, read pointer increments.
- With no pop, `write` = 0 and `data` holds its last value.
- Push and pop in the same cycle leave `fill` unchanged; otherwise `fill` moves by +1 or −1.
- Window position is tracked per pop:
  - If `window_cnt == WINDOW-1`: `window_cnt` wraps to 0 and `window_done` = 1 alongside that `write`.
  - Otherwise `window_cnt` increments and `window_done` = 0.
- `window_done` is never high without `write`.
- `flush` (when `rst` = 0):
  - Next state: `fill` = 0, both pointers = 0, `window_cnt` = 0, `write` = 0, `window_done` = 0.
  - A sample offered during the flush cycle is not accepted (`in_ready` = 0).
  - `data` keeps its value.
- `rst` has priority over `flush`. All state clears on the edge with `rst` = 1, including mid-window and with a non-empty FIFO.
- `data` carries samples byte-for-byte, with no arithmetic applied. Counters wrap only as stated above and never saturate.

## Timing
- Reset values: `write` 0, `data` 8'h00, `fill` 0, `window_cnt` 0, `window_done` 0. `in_ready` is 0 while `rst` = 1 and 1 in the first cycle after reset releases.
- Latency: a sample accepted at edge k into an empty FIFO with `hold` = 0 appears with `write` = 1 in the cycle after edge k+1. Minimum one cycle of buffering; there is no combinational bypass.
- Throughput: one sample per cycle sustained when `in_valid` = 1 and `hold` = 0. `fill` stays at 0/1 in this case.
- `hold` acts on the cycle it is sampled. If `hold` rises at edge k, there is no `write` in the cycle after edge k. In-flight `write` values are not retracted.
- `fill` and `window_cnt` reflect state after the most recent edge.

## Test plan
- Reset and idle:
  - Hold `rst` = 1 for 3 cycles with `in_valid` = 1 -> `in_ready` = 0, all outputs at reset values, no `write`.
  - After release -> `in_ready` = 1 next cycle.
- Streaming:
  - Push 0x00..0xFF back-to-back with `hold` = 0 -> `write` appears one cycle after each acceptance, `data` in order, `fill` ≤ 1.
  - After 256 writes -> `window_cnt` = 256.
- Backpressure and full:
  - Set `hold` = 1 and push 20 samples (DEPTH = 16) -> first 16 accepted, `in_ready` = 0 at `fill` = 16.
  - Release `hold` -> 16 writes in order, then the remaining 4 are accepted, with no loss or duplication.
- Window wrap:
  - Stream 2050 samples -> `window_done` high exactly on writes #1024 and #2048 (1-based).
  - `window_cnt` returns to 0 after each, and equals 2 at the end.
- Simultaneous push/pop at full:
  - `fill` = 16, then `hold` = 0 with `in_valid` = 1 -> `in_ready` stays 0 that cycle and `fill` drops to 15.
  - Push accepted on the following cycle.
- Flush and reset mid-operation:
  - At `fill` = 5, `window_cnt` = 700, assert `flush` one cycle with `in_valid` = 1 -> next cycle `fill` 0, `window_cnt` 0, `write` 0, and the offered sample is dropped.
  - Repeat with `rst` + `flush` together -> identical cleared state.

Source files
------------

// File: rtl/sample_window_feeder.sv
// rtl/sample_window_feeder.sv - sample FIFO feeding the histogram stage with window tracking
// Buffers 8-bit samples and drains them one per cycle as a registered write/data strobe.
module sample_window_feeder #(
  parameter int DEPTH  = 16,
  parameter int WINDOW = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  input  logic                       hold,
  output logic                       write,
  output logic [7:0]                 data,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [$clog2(WINDOW)-1:0]  window_cnt,
  output logic                       window_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(WINDOW);
  localparam logic [AW:0]   FULL_FILL = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] LAST_POS  = WW'(WINDOW - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // No pass-through: a full FIFO refuses input even while it drains.
  assign in_ready = ~rst & ~flush & (fill != FULL_FILL);
  assign push     = in_valid & in_ready;
  assign pop      = (fill != '0) & ~hold & ~flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      window_cnt  <= '0;
      write       <= 1'b0;
      window_done <= 1'b0;
      data        <= 8'h00;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      window_cnt  <= '0;
      write       <= 1'b0;
      window_done <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        write  <= 1'b1;
        data   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
        if (window_cnt == LAST_POS) begin
          window_cnt  <= '0;
          window_done <= 1'b1;
        end else begin
          window_cnt  <= window_cnt + WW'(1);
          window_done <= 1'b0;
        end
      end else begin
        write       <= 1'b0;
        window_done <= 1'b0;
      end
      case ({push, pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_window_feeder.sv
// tb/tb_sample_window_feeder.sv - directed scoreboard bench for sample_window_feeder
module tb_sample_window_feeder;

  localparam int DEPTH  = 16;
  localparam int WINDOW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        hold = 1'b0;
  logic        write;
  logic [7:0]  data;
  logic [4:0]  fill;
  logic [9:0]  window_cnt;
  logic        window_done;

  sample_window_feeder #(.DEPTH(DEPTH), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .hold(hold), .write(write), .data(data), .fill(fill),
    .window_cnt(window_cnt), .window_done(window_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb[$];
  int         mfill = 0;
  int         mwin = 0;
  bit         mwrite = 0;
  bit         mdone = 0;
  logic [7:0] mdata = 8'h00;
  bit         last_acc = 0;
  int         nwr = 0;
  int         ndone = 0;
  int         done_at[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic cyc();
    bit exp_ready;
    bit pop;
    @(negedge clk);
    exp_ready = !rst && !flush && (mfill != DEPTH);
    chk("in_ready", in_ready, exp_ready);
    last_acc = in_valid && exp_ready;
    pop = !rst && !flush && (mfill != 0) && !hold;
    if (rst) begin
      sb.delete(); mfill = 0; mwin = 0; mwrite = 0; mdone = 0; mdata = 8'h00;
    end else if (flush) begin
      sb.delete(); mfill = 0; mwin = 0; mwrite = 0; mdone = 0;
    end else begin
      mwrite = pop;
      mdone = 0;
      if (pop) begin
        mdata = sb.pop_front();
        mdone = (mwin == WINDOW - 1);
        mwin = mdone ? 0 : mwin + 1;
      end
      if (last_acc) sb.push_back(in_data);
      mfill = mfill + (last_acc ? 1 : 0) - (pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
    chk("write", write, mwrite);
    chk("data", data, mdata);
    chk("window_done", window_done, mdone);
    chk("fill", fill, mfill);
    chk("window_cnt", window_cnt, mwin);
    if (write) nwr++;
    if (window_done) begin
      ndone++;
      done_at.push_back(nwr);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    cyc();
    rst = 1'b0;
    nwr = 0; ndone = 0; done_at.delete();
  endtask

  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = 8'(base + i);
      cyc();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
  endtask

  task automatic fill_held(input int n, input int base);
    hold = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = 8'(base + i);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int idx;

    // reset held with valid offered
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_write", write, 1'b0);
    chk("rst_data", data, 8'h00);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1'b1);
    cyc();

    // streaming 0x00..0xFF
    nwr = 0;
    stream(256, 0);
    chk("stream_writes", nwr, 256);
    chk("stream_window_cnt", window_cnt, 256);

    // backpressure with 20 offers, retried until accepted
    idx = 0;
    hold = 1'b1;
    for (int c = 0; c < 80 && idx < 20; c++) begin
      if (c == 20) hold = 1'b0;
      in_valid = 1'b1;
      in_data = 8'(8'hA0 + idx);
      cyc();
      if (last_acc) idx++;
      if (c == 19) begin
        chk("bp_full_fill", fill, 16);
        chk("bp_full_ready", in_ready, 1'b0);
        chk("bp_accepted", idx, 16);
      end
    end
    in_valid = 1'b0;
    chk("bp_all_sent", idx, 20);
    for (int i = 0; i < 20; i++) cyc();
    chk("bp_drained", sb.size(), 0);
    chk("bp_window_cnt", window_cnt, 276);

    // window wrap over 2050 samples
    do_reset();
    stream(2050, 3);
    chk("wrap_writes", nwr, 2050);
    chk("wrap_done_count", ndone, 2);
    if (done_at.size() == 2) begin
      chk("wrap_done_first", done_at[0], 1024);
      chk("wrap_done_second", done_at[1], 2048);
    end
    chk("wrap_window_cnt", window_cnt, 2);

    // simultaneous push/pop while full
    do_reset();
    fill_held(16, 8'h40);
    chk("full_fill", fill, 16);
    hold = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    cyc();
    chk("full_no_accept", last_acc, 1'b0);
    chk("full_pop_fill", fill, 15);
    chk("full_ready_next", in_ready, 1'b1);
    in_data = 8'h56;
    cyc();
    in_valid = 1'b0;
    chk("full_accept_fill", fill, 15);
    for (int i = 0; i < 20; i++) cyc();
    chk("full_drained", fill, 0);

    // flush mid-window
    do_reset();
    stream(700, 0);
    fill_held(5, 8'hC0);
    chk("pre_flush_fill", fill, 5);
    chk("pre_flush_window", window_cnt, 700);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; hold = 1'b0;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_fill", fill, 0);
    chk("flush_window", window_cnt, 0);
    chk("flush_write", write, 1'b0);
    cyc();
    chk("flush_dropped", write, 1'b0);

    // rst and flush together mid-window
    stream(700, 0);
    fill_held(5, 8'hD0);
    chk("pre_rst_fill", fill, 5);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'hEF; hold = 1'b0;
    cyc();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rstf_fill", fill, 0);
    chk("rstf_window", window_cnt, 0);
    chk("rstf_write", write, 1'b0);
    chk("rstf_data", data, 8'h00);
    cyc();
    chk("rstf_dropped", write, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
